// File: rtl/proc_ctrl.sv
// proc_ctrl: IR, time-step counter and per-step datapath control decode.
// Optional MVNZ_EN makes opcode 100 a conditional move gated by GNZ.
module proc_ctrl (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Run,
  input  logic [8:0] DIN,
  input  logic       GNZ,
  output logic [8:0] IR,
  output logic [1:0] Tstep,
  output logic       IRin,
  output logic [2:0] RinSel,
  output logic       RinEn,
  output logic [2:0] RoutSel,
  output logic       RoutEn,
  output logic       DINout,
  output logic       Gout,
  output logic       Ain,
  output logic       Gin,
  output logic       AddSub,
  output logic       Done
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_e;

  step_e      tstep_q, tstep_d;
  logic [8:0] ir_q, ir_d;

  logic [2:0] op, rx, ry;
  logic       is_mv, is_mvi, is_add, is_sub;
  logic       is_mvnz, mvnz_go;

  assign op = ir_q[8:6];
  assign rx = ir_q[5:3];
  assign ry = ir_q[2:0];

  assign is_mv  = (op == 3'b000);
  assign is_mvi = (op == 3'b001);
  assign is_add = (op == 3'b010);
  assign is_sub = (op == 3'b011);

`ifdef MVNZ_EN
  assign is_mvnz = (op == 3'b100);
  assign mvnz_go = is_mvnz & GNZ;
`else
  logic unused_gnz;
  assign unused_gnz = GNZ;
  assign is_mvnz    = 1'b0;
  assign mvnz_go    = 1'b0;
`endif

  // Register fields stay 0 unless the matching enable is high.
  always_comb begin
    IRin    = 1'b0;
    RinSel  = 3'd0;
    RinEn   = 1'b0;
    RoutSel = 3'd0;
    RoutEn  = 1'b0;
    DINout  = 1'b0;
    Gout    = 1'b0;
    Ain     = 1'b0;
    Gin     = 1'b0;
    AddSub  = 1'b0;
    Done    = 1'b0;
    if (!Reset) begin
      unique case (tstep_q)
        T0: IRin = Run;
        T1: begin
          unique case (1'b1)
            is_mv, mvnz_go: begin
              RoutSel = ry;
              RoutEn  = 1'b1;
              RinSel  = rx;
              RinEn   = 1'b1;
              Done    = 1'b1;
            end
            is_mvi: begin
              DINout = 1'b1;
              RinSel = rx;
              RinEn  = 1'b1;
              Done   = 1'b1;
            end
            is_add, is_sub: begin
              RoutSel = rx;
              RoutEn  = 1'b1;
              Ain     = 1'b1;
            end
            default: Done = 1'b1;
          endcase
        end
        T2: begin
          if (is_add || is_sub) begin
            RoutSel = ry;
            RoutEn  = 1'b1;
            Gin     = 1'b1;
            AddSub  = is_sub;
          end
        end
        T3: begin
          if (is_add || is_sub) begin
            Gout   = 1'b1;
            RinSel = rx;
            RinEn  = 1'b1;
            Done   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Steps other than T0 never load IR; Run is ignored there.
  always_comb begin
    tstep_d = tstep_q;
    ir_d    = ir_q;
    if (tstep_q == T0) begin
      if (Run) begin
        ir_d    = DIN;
        tstep_d = T1;
      end
    end else if (Done) begin
      tstep_d = T0;
    end else if (tstep_q != T3) begin
      tstep_d = step_e'(tstep_q + 2'd1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      tstep_q <= T0;
      ir_q    <= 9'd0;
    end else begin
      tstep_q <= tstep_d;
      ir_q    <= ir_d;
    end
  end

  assign IR    = ir_q;
  assign Tstep = tstep_q;

  logic unused_mvnz;
  assign unused_mvnz = is_mvnz;

endmodule

// File: tb/tb_proc_ctrl.sv
// Directed bench for proc_ctrl: reset, mv, mvi, sub, aborted add,
// back-to-back Run, mvnz/NOP decode.
module tb_proc_ctrl;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Run;
  logic [8:0] DIN;
  logic       GNZ;
  logic [8:0] IR;
  logic [1:0] Tstep;
  logic       IRin, RinEn, RoutEn;
  logic [2:0] RinSel, RoutSel;
  logic       DINout, Gout, Ain, Gin, AddSub, Done;

  int total = 0;
  int bad   = 0;

  proc_ctrl dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Run     (Run),
    .DIN     (DIN),
    .GNZ     (GNZ),
    .IR      (IR),
    .Tstep   (Tstep),
    .IRin    (IRin),
    .RinSel  (RinSel),
    .RinEn   (RinEn),
    .RoutSel (RoutSel),
    .RoutEn  (RoutEn),
    .DINout  (DINout),
    .Gout    (Gout),
    .Ain     (Ain),
    .Gin     (Gin),
    .AddSub  (AddSub),
    .Done    (Done)
  );

  always #5 Clock = ~Clock;

  logic [14:0] ctl;
  assign ctl = {IRin, RinSel, RinEn, RoutSel, RoutEn,
                DINout, Gout, Ain, Gin, AddSub, Done};

  function automatic logic [14:0] mk(
    input bit irin, input logic [2:0] rin, input bit rinen,
    input logic [2:0] rout, input bit routen, input bit dinout,
    input bit gout, input bit ain, input bit gin,
    input bit addsub, input bit done);
    return {irin, rin, rinen, rout, routen,
            dinout, gout, ain, gin, addsub, done};
  endfunction

  task automatic chk(input string tag, input logic [14:0] obs,
                     input logic [14:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  localparam logic [14:0] NONE  = 15'd0;
  localparam logic [14:0] DONE1 = 15'd1;
  localparam logic [14:0] IRIN1 = 15'h4000;

  initial begin
    Reset = 1'b1;
    Run   = 1'b1;
    DIN   = 9'o123;
    GNZ   = 1'b0;
    #2;
    chk("rst_ctl_early", ctl, NONE);
    tick();
    chk("rst_ctl_c1", ctl, NONE);
    chk("rst_tstep_c1", {13'd0, Tstep}, 15'd0);
    chk("rst_ir_c1", {6'd0, IR}, 15'd0);
    tick();
    chk("rst_ctl_c2", ctl, NONE);
    Reset = 1'b0;
    Run   = 1'b0;
    #1;
    chk("rel_tstep", {13'd0, Tstep}, 15'd0);
    chk("rel_ir", {6'd0, IR}, 15'd0);
    chk("rel_ctl", ctl, NONE);

    // mv R3,R5
    Run = 1'b1;
    DIN = 9'b000_011_101;
    #1;
    chk("mv_t0", ctl, IRIN1);
    tick();
    Run = 1'b0;
    #1;
    chk("mv_tstep1", {13'd0, Tstep}, 15'd1);
    chk("mv_ir", {6'd0, IR}, {6'd0, 9'b000_011_101});
    chk("mv_t1", ctl, mk(0, 3'd3, 1, 3'd5, 1, 0, 0, 0, 0, 0, 1));
    tick();
    chk("mv_back_t0", {13'd0, Tstep}, 15'd0);
    chk("mv_idle", ctl, NONE);

    // mvi R2,#77
    Run = 1'b1;
    DIN = 9'b001_010_000;
    #1;
    chk("mvi_t0", ctl, IRIN1);
    tick();
    Run = 1'b0;
    DIN = 9'd77;
    #1;
    chk("mvi_t1", ctl, mk(0, 3'd2, 1, 3'd0, 0, 1, 0, 0, 0, 0, 1));
    chk("mvi_ir_hold", {6'd0, IR}, {6'd0, 9'b001_010_000});
    tick();
    chk("mvi_back_t0", {13'd0, Tstep}, 15'd0);

    // sub R1,R6
    Run = 1'b1;
    DIN = 9'b011_001_110;
    #1;
    chk("sub_t0", ctl, IRIN1);
    tick();
    Run = 1'b0;
    #1;
    chk("sub_t1", ctl, mk(0, 3'd0, 0, 3'd1, 1, 0, 0, 1, 0, 0, 0));
    tick();
    chk("sub_tstep2", {13'd0, Tstep}, 15'd2);
    chk("sub_t2", ctl, mk(0, 3'd0, 0, 3'd6, 1, 0, 0, 0, 1, 1, 0));
    tick();
    chk("sub_tstep3", {13'd0, Tstep}, 15'd3);
    chk("sub_t3", ctl, mk(0, 3'd1, 1, 3'd0, 0, 0, 1, 0, 0, 0, 1));
    tick();
    chk("sub_back_t0", {13'd0, Tstep}, 15'd0);
    chk("sub_idle", ctl, NONE);

    // add R3,R4 aborted by reset in T2
    Run = 1'b1;
    DIN = 9'b010_011_100;
    #1;
    tick();
    Run = 1'b0;
    #1;
    chk("add_t1", ctl, mk(0, 3'd0, 0, 3'd3, 1, 0, 0, 1, 0, 0, 0));
    tick();
    chk("add_t2", ctl, mk(0, 3'd0, 0, 3'd4, 1, 0, 0, 0, 1, 0, 0));
    Reset = 1'b1;
    #1;
    chk("abort_ctl", ctl, NONE);
    tick();
    chk("abort_tstep", {13'd0, Tstep}, 15'd0);
    chk("abort_ir", {6'd0, IR}, 15'd0);
    Reset = 1'b0;
    #1;

    // back-to-back mv R1,R2 ; mv R4,R3 with Run held high
    Run = 1'b1;
    DIN = 9'b000_001_010;
    #1;
    chk("b2b_t0a", ctl, IRIN1);
    tick();
    DIN = 9'b000_100_011;
    #1;
    chk("b2b_t1a", ctl, mk(0, 3'd1, 1, 3'd2, 1, 0, 0, 0, 0, 0, 1));
    chk("b2b_ir_hold", {6'd0, IR}, {6'd0, 9'b000_001_010});
    tick();
    chk("b2b_t0b", ctl, IRIN1);
    chk("b2b_t0b_step", {13'd0, Tstep}, 15'd0);
    tick();
    Run = 1'b0;
    #1;
    chk("b2b_t1b", ctl, mk(0, 3'd4, 1, 3'd3, 1, 0, 0, 0, 0, 0, 1));
    tick();
    chk("b2b_idle", ctl, NONE);

    // opcode 100 with GNZ=1 then GNZ=0
    Run = 1'b1;
    DIN = 9'b100_100_111;
    GNZ = 1'b1;
    #1;
    tick();
    Run = 1'b0;
    #1;
`ifdef MVNZ_EN
    chk("op4_gnz1", ctl, mk(0, 3'd4, 1, 3'd7, 1, 0, 0, 0, 0, 0, 1));
`else
    chk("op4_gnz1", ctl, DONE1);
`endif
    tick();
    chk("op4_back_t0", {13'd0, Tstep}, 15'd0);
    Run = 1'b1;
    GNZ = 1'b0;
    #1;
    tick();
    Run = 1'b0;
    #1;
    chk("op4_gnz0", ctl, DONE1);
    tick();

    // opcode 111 is always a NOP
    Run = 1'b1;
    DIN = 9'b111_101_010;
    GNZ = 1'b1;
    #1;
    tick();
    Run = 1'b0;
    #1;
    chk("nop7_t1", ctl, DONE1);
    tick();
    chk("nop7_back_t0", {13'd0, Tstep}, 15'd0);
    chk("nop7_idle", ctl, NONE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/proc_ctrl.md
# proc_ctrl

- Control unit for the simple processor.
- Holds the 9-bit instruction register (IR) and a 2-bit time-step counter.
- Generates the per-step datapath controls, including the 3-bit register-select fields and enables that drive the two 3-to-8 register decoders: one for register-in, one for register-out.
- Sits between the instruction source (DIN/Run) and the decoders and datapath muxes.

## Interface
Parameters:
- None. Instruction format is fixed: IR[8:6]=opcode III, IR[5:3]=X register, IR[2:0]=Y register.

Ports:
- Clock  in  1  Single clock; all state updates on the rising edge.
- Reset  in  1  Synchronous, active-high reset.
- Run  in  1  Start request; sampled only in step T0.
- DIN  in  9  Instruction word; DIN is also the immediate source for mvi.
- GNZ  in  1  G register is nonzero (used only with MVNZ_EN).
- IR  out  9  Instruction register contents.
- Tstep  out  2  Current time step (0..3).
- IRin  out  1  Load IR from DIN.
- RinSel  out  3  Register-in index; drives the decoder W input.
- RinEn  out  1  Register-in decoder enable.
- RoutSel  out  3  Register-out index; drives the decoder W input.
- RoutEn  out  1  Register-out decoder enable.
- DINout  out  1  Drive DIN onto the bus.
- Gout  out  1  Drive G onto the bus.
- Ain  out  1  Load A from the bus.
- Gin  out  1  Load G with the ALU result.
- AddSub  out  1  ALU mode: 0 = add, 1 = sub.
- Done  out  1  Instruction completes in this cycle.

## Operation
Opcodes: 000 mv, 001 mvi, 010 add, 011 sub, 100–111 NOP (see Configuration).

Step sequence. Any control not listed for a step is 0.
- T0: IRin=Run. If Run, IR<=DIN and Tstep<=1; otherwise stay in T0.
- mv, T1: RoutSel=Y, RoutEn, RinSel=X, RinEn, Done.
- mvi, T1: DINout, RinSel=X, RinEn, Done.
- add/sub, T1: RoutSel=X, RoutEn, Ain.
- add/sub, T2: RoutSel=Y, RoutEn, Gin, AddSub=(opcode==011).
- add/sub, T3: Gout, RinSel=X, RinEn, Done.
- NOP, T1: Done only.

Step counter and IR:
- When Done=1, the next Tstep is 0. Otherwise Tstep increments by 1.
- Tstep never wraps 3→0 without Done.
- IR changes only on IRin in T0; it holds for the whole instruction.
- RinSel/RoutSel are 0 whenever their enable is 0.

## Timing
Reset:
- Reset sampled high: Tstep<=0 and IR<=0 on that edge.
- While Reset is high, every output except IR and Tstep is forced to 0 combinationally, including in the same cycle.
- After release: Tstep=0, IR=0, all controls 0 until Run.

Output timing:
- All controls are combinational from Tstep, IR, Run and GNZ, valid in the same cycle as their step.
- IRin and Run are the only Mealy path.

Latency, from the Run cycle to Done:
- 1 cycle for mv, mvi and NOP, so 2 cycles per instruction including T0.
- 3 cycles for add/sub, so 4 cycles including T0.

Boundary conditions:
- mvi: upstream must present the immediate on DIN during T1, the cycle after the instruction was loaded.
- Run asserted outside T0 is ignored. Run held high issues back-to-back instructions with no idle cycle.
- Reset mid-instruction (any Tstep) aborts: no RinEn/Gin in that cycle; next state is T0 with IR=0.

## Configuration
- MVNZ_EN defined: opcode 100 is mvnz. In T1, if GNZ=1, behave as mv (RoutSel=Y, RoutEn, RinSel=X, RinEn); if GNZ=0, assert no register controls. Done is asserted in T1 in both cases. GNZ is sampled in T1.
- MVNZ_EN undefined: opcode 100 is a NOP like 101–111, and GNZ is unused.

## Test plan
- **Reset.** Reset=1 for 2 cycles with Run=1 and DIN=9'o123. Required: all controls 0 while Reset is high; after release, Tstep=0, IR=0 and Done=0.
- **mv.** Run=1 with DIN=9'b000_011_101 (mv R3,R5). Required: T0 IRin=1; T1 RoutSel=5, RoutEn=1, RinSel=3, RinEn=1, Done=1; next cycle Tstep=0.
- **mvi.** DIN=9'b001_010_000, then DIN=9'd77 in T1. Required: T1 DINout=1, RinSel=2, RinEn=1, Done=1.
- **sub.** DIN=9'b011_001_110 (sub R1,R6). Required: T1 RoutSel=1, Ain=1; T2 RoutSel=6, Gin=1, AddSub=1; T3 Gout=1, RinSel=1, RinEn=1, Done=1; then Tstep=0.
- **Reset mid-instruction.** Reset asserted during T2 of add. Required: Gin=0 that cycle; next cycle Tstep=0 and IR=0. Run held high across back-to-back mv,mv: the second IRin occurs in the cycle right after the first Done.
- **mvnz (MVNZ_EN defined).** DIN=9'b100_100_111: with GNZ=1, T1 RoutSel=7, RinSel=4, both enables=1, Done=1; with GNZ=0, only Done=1. Without MVNZ_EN, both cases give only Done=1.
